// File: rtl/echo_timer_pkg.sv
// Shared delay-line definitions: FSM state encoding and counter width helper,
// common to echo_timer and the transmit burst generator.
package echo_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BLANK   = 2'd1,
        ST_LISTEN  = 2'd2,
        ST_QUALIFY = 2'd3
    } state_t;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/echo_timer_sync_edge.sv
// Receive-comparator synchroniser and rising-edge detector (module sync_edge).
// GLITCH_FILTER=1 requires two consecutive high samples after a low one.
module sync_edge #(
    parameter bit GLITCH_FILTER = 1'b0
) (
    input  logic clk,
    input  logic n_reset,
    input  logic rx_in,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic prev_1;
    logic prev_2;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            prev_1 <= 1'b0;
            prev_2 <= 1'b0;
        end else begin
            sync_1 <= rx_in;
            sync_2 <= sync_1;
            prev_1 <= sync_2;
            prev_2 <= prev_1;
        end
    end

    // Filtered edge fires on the second high sample, one cycle after a plain edge.
    assign rise = GLITCH_FILTER ? (sync_2 & prev_1 & ~prev_2) : (sync_2 & ~prev_1);

endmodule

// File: rtl/echo_timer.sv
// Time-of-flight receiver: blanks transmit ringing, qualifies an edge burst, reports tof or timeout.
// Optional glitch filter on the receive path: define ECHO_TIMER_GLITCH_FILTER_EN.
module echo_timer
    import echo_timer_pkg::*;
#(
    parameter int TOF_WIDTH   = 16,
    parameter int BLANK_CLKS  = 20,
    parameter int MIN_EDGES   = 2,
    parameter int EDGE_WINDOW = 8,
    parameter int MAX_CLKS    = 50000
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 start,
    input  logic                 rx_in,
    output logic                 busy,
    output logic [TOF_WIDTH-1:0] tof,
    output logic                 tof_valid,
    output logic                 timeout
);

`ifdef ECHO_TIMER_GLITCH_FILTER_EN
    localparam bit GLITCH_FILTER = 1'b1;
`else
    localparam bit GLITCH_FILTER = 1'b0;
`endif

    localparam int WIN_W = width_for(EDGE_WINDOW - 1);
    localparam int EC_W  = width_for(MIN_EDGES);

    localparam logic [TOF_WIDTH-1:0] BLANK_LAST = TOF_WIDTH'(BLANK_CLKS - 1);
    localparam logic [TOF_WIDTH-1:0] CTR_LAST   = TOF_WIDTH'(MAX_CLKS - 1);
    localparam logic [WIN_W-1:0]     WIN_LAST   = WIN_W'(EDGE_WINDOW - 1);
    localparam logic [EC_W-1:0]      EC_LAST    = EC_W'(MIN_EDGES - 1);

    state_t                 state;
    logic [TOF_WIDTH-1:0]   ctr;
    logic [TOF_WIDTH-1:0]   tof_cap;
    logic [WIN_W-1:0]       win;
    logic [EC_W-1:0]        edge_cnt;
    logic                   rise;
    logic                   report;
    logic [TOF_WIDTH-1:0]   report_val;

    sync_edge #(
        .GLITCH_FILTER(GLITCH_FILTER)
    ) u_sync_edge (
        .clk    (clk),
        .n_reset(n_reset),
        .rx_in  (rx_in),
        .rise   (rise)
    );

    // A qualifying edge this cycle; it takes priority over a coincident timeout.
    always_comb begin
        report     = 1'b0;
        report_val = tof_cap;
        if (state == ST_LISTEN && rise && MIN_EDGES == 1) begin
            report     = 1'b1;
            report_val = ctr;
        end else if (state == ST_QUALIFY && rise && edge_cnt == EC_LAST) begin
            report     = 1'b1;
            report_val = tof_cap;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= ST_IDLE;
            ctr       <= '0;
            tof_cap   <= '0;
            win       <= '0;
            edge_cnt  <= '0;
            tof       <= '0;
            tof_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            tof_valid <= 1'b0;
            timeout   <= 1'b0;
            if (state != ST_IDLE) begin
                ctr <= ctr + 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ctr      <= '0;
                        win      <= '0;
                        edge_cnt <= '0;
                        state    <= ST_BLANK;
                    end
                end
                ST_BLANK: begin
                    if (ctr == BLANK_LAST) begin
                        state <= ST_LISTEN;
                    end
                end
                ST_LISTEN: begin
                    if (rise) begin
                        tof_cap  <= ctr;
                        edge_cnt <= EC_W'(1);
                        win      <= '0;
                        state    <= ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    if (rise) begin
                        edge_cnt <= edge_cnt + 1'b1;
                        win      <= '0;
                    end else if (win == WIN_LAST) begin
                        edge_cnt <= '0;
                        tof_cap  <= '0;
                        win      <= '0;
                        state    <= ST_LISTEN;
                    end else begin
                        win <= win + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (report) begin
                tof       <= report_val;
                tof_valid <= 1'b1;
                state     <= ST_IDLE;
            end else if (state != ST_IDLE && ctr == CTR_LAST) begin
                timeout <= 1'b1;
                state   <= ST_IDLE;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_echo_timer.sv
// Directed bench for echo_timer: per-cycle strobe/busy checks and a tof scoreboard.
// Builds with or without ECHO_TIMER_GLITCH_FILTER_EN; expectations follow the macro.
module tb_echo_timer;

    localparam int TW    = 16;
    localparam int BLANK = 20;
    localparam int MINE  = 2;
    localparam int EWIN  = 8;
    localparam int MAXC  = 200;
`ifdef ECHO_TIMER_GLITCH_FILTER_EN
    localparam int FOFF  = 1;
    localparam bit FILT  = 1'b1;
`else
    localparam int FOFF  = 0;
    localparam bit FILT  = 1'b0;
`endif

    logic          clk;
    logic          n_reset;
    logic          start;
    logic          rx_in;
    logic          busy;
    logic [TW-1:0] tof;
    logic          tof_valid;
    logic          timeout;

    int            n_tests;
    int            n_fail;
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] last_tof;
    int            edges[$];
    int            pw;

    echo_timer #(
        .TOF_WIDTH  (TW),
        .BLANK_CLKS (BLANK),
        .MIN_EDGES  (MINE),
        .EDGE_WINDOW(EWIN),
        .MAX_CLKS   (MAXC)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .start    (start),
        .rx_in    (rx_in),
        .busy     (busy),
        .tof      (tof),
        .tof_valid(tof_valid),
        .timeout  (timeout)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // rx is high for pw cycles starting two cycles before each synchronised edge.
    function automatic logic rx_at(input int k);
        foreach (edges[i]) begin
            if (k >= edges[i] - 2 && k < edges[i] - 2 + pw) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Start a run and step it cycle by cycle; exp_rep is the ctr of the report, -1 for timeout.
    task automatic run_case(input string name, input int exp_rep, input int exp_tof,
                            input int start_at);
        int end_k;
        end_k = (exp_rep >= 0) ? exp_rep : MAXC - 1;
        if (exp_rep >= 0) exp_q.push_back(TW'(exp_tof));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= end_k + 1; k++) begin
            check_val({name, "_busy"}, busy, (k <= end_k));
            check_val({name, "_tof_valid"}, tof_valid, (exp_rep >= 0 && k == end_k + 1));
            check_val({name, "_timeout"}, timeout, (exp_rep < 0 && k == end_k + 1));
            if (tof_valid) begin
                if (exp_q.size() > 0) begin
                    check_val({name, "_tof"}, tof, exp_q.pop_front());
                    last_tof = TW'(exp_tof);
                end else begin
                    check_val({name, "_sb_underflow"}, 1, 0);
                end
            end
            if (timeout) check_val({name, "_tof_held"}, tof, last_tof);
            rx_in = rx_at(k);
            start = (k == start_at);
            @(posedge clk); #1;
        end
        rx_in = 1'b0;
        start = 1'b0;
        check_val({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        last_tof = '0;
        pw       = 2;
        n_reset  = 1'b0;
        start    = 1'b0;
        rx_in    = 1'b0;

        // 1: inputs toggling under reset leave every output at zero
        for (int k = 0; k < 6; k++) begin
            rx_in = k[0];
            start = ~k[0];
            @(posedge clk); #1;
            check_val("rst_busy", busy, 0);
            check_val("rst_tof", tof, 0);
            check_val("rst_tof_valid", tof_valid, 0);
            check_val("rst_timeout", timeout, 0);
        end
        rx_in = 1'b0;
        start = 1'b0;
        n_reset = 1'b1;
        @(posedge clk); #1;

        // 2: basic echo; start held in the last busy cycle is ignored
        edges = '{50, 54};
        run_case("basic", 54 + FOFF, 50 + FOFF, 54 + FOFF);

        // 3: ringing inside the blanking window
        edges = '{5, 10, 60, 63};
        run_case("blank", 63 + FOFF, 60 + FOFF, -1);

        // 4: lone edge expires, later burst qualifies
        edges = '{40, 100, 104};
        run_case("expire", 104 + FOFF, 100 + FOFF, -1);

        // 5: silence -> timeout, tof held
        edges = {};
        run_case("timeout", -1, 0, -1);

        // 6: start while busy is ignored
        edges = '{50, 54};
        run_case("busy_start", 54 + FOFF, 50 + FOFF, 30);

        // 6b: asynchronous reset while listening
        edges = {};
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
        end
        check_val("listen_busy", busy, 1);
        #2 n_reset = 1'b0;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_tof", tof, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_val("arst_tof_valid", tof_valid, 0);
            check_val("arst_timeout", timeout, 0);
            check_val("arst_busy_hold", busy, 0);
        end
        n_reset = 1'b1;
        last_tof = '0;
        @(posedge clk); #1;

        // 7: single-cycle pulses (rejected only with the filter), then 2-cycle pulses
        pw = 1;
        edges = '{50, 54};
        if (FILT) run_case("short_pulse", -1, 0, -1);
        else      run_case("short_pulse", 54, 50, -1);
        pw = 2;
        run_case("long_pulse", 54 + FOFF, 50 + FOFF, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
